riscv_i32c_fetch_align: RTL

RISCV_I32C_FETCH_ALIGN -- requirements
Module: riscv_i32c_fetch_align

---
 rtl/riscv_i32c_fetch_align.sv | 111 +++++++++++
 1 files changed

// File: rtl/riscv_i32c_fetch_align.sv
// Fetch aligner for RV32IC: returns a 32-bit instruction window at any halfword address,
// using a one-word hold buffer so that aligned and compressed hits skip the SRAM.
module riscv_i32c_fetch_align #(
  parameter int SRAM_AW = 14
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               req_valid,
  input  logic [31:0]        req_address,
  output logic               req_ready,
  output logic               resp_valid,
  output logic [31:0]        resp_data,
  output logic               sram_select,
  output logic [SRAM_AW-1:0] sram_address,
  input  logic [31:0]        sram_read_data
);

  typedef enum logic [1:0] {IDLE, FIRST, LAST, RESP} state_t;

  state_t      state, state_nxt;
  logic        run;           // rises on the first edge after reset release
  logic        hold_valid;
  logic [29:0] hold_word;
  logic [31:0] hold_data;
  logic [29:0] cur_word;
  logic        cur_mis;

  logic [29:0] req_word, rd_word, hold_word_nxt;
  logic        accept, hit, hold_hi_32, hold_ld;
  logic        addr_unused;

  assign req_word     = req_address[31:2];
  assign hit          = hold_valid && (hold_word == req_word);
  assign hold_hi_32   = (hold_data[17:16] == 2'b11);
  assign req_ready    = run && (state == IDLE) && !flush;
  assign accept       = req_valid && req_ready;
  assign sram_address = rd_word[SRAM_AW-1:0];
  assign addr_unused  = ^{req_address[0], rd_word};

  always_comb begin
    state_nxt     = state;
    sram_select   = 1'b0;
    rd_word       = req_word;
    resp_valid    = 1'b0;
    resp_data     = '0;
    hold_ld       = 1'b0;
    hold_word_nxt = cur_word;
    case (state)
      IDLE: if (accept) begin
        if (hit && (!req_address[1] || !hold_hi_32)) begin
          state_nxt = RESP;
        end else begin
          sram_select = 1'b1;
          // a misaligned hit already has the low half; fetch the following word only
          rd_word     = (req_address[1] && hit) ? req_word + 30'd1 : req_word;
          state_nxt   = (req_address[1] && !hit) ? FIRST : LAST;
        end
      end
      FIRST: if (!flush) begin
        sram_select   = 1'b1;
        rd_word       = cur_word + 30'd1;
        hold_ld       = 1'b1;
        hold_word_nxt = cur_word;
        state_nxt     = LAST;
      end
      LAST: if (!flush) begin
        resp_valid    = 1'b1;
        resp_data     = cur_mis ? {sram_read_data[15:0], hold_data[31:16]} : sram_read_data;
        hold_ld       = 1'b1;
        hold_word_nxt = cur_mis ? cur_word + 30'd1 : cur_word;
        state_nxt     = IDLE;
      end
      RESP: if (!flush) begin
        resp_valid = 1'b1;
        resp_data  = cur_mis ? {16'h0, hold_data[31:16]} : hold_data;
        state_nxt  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      run        <= 1'b0;
      hold_valid <= 1'b0;
      hold_word  <= '0;
      hold_data  <= '0;
      cur_word   <= '0;
      cur_mis    <= 1'b0;
    end else begin
      run <= 1'b1;
      if (flush) begin
        state      <= IDLE;
        hold_valid <= 1'b0;
      end else begin
        state <= state_nxt;
        if (hold_ld) begin
          hold_valid <= 1'b1;
          hold_word  <= hold_word_nxt;
          hold_data  <= sram_read_data;
        end
      end
      if (accept) begin
        cur_word <= req_word;
        cur_mis  <= req_address[1];
      end
    end
  end

endmodule
